// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync FIFO packet reader: word layout and FSM states.
package sync_fifo_pkg;

    localparam int DATA_W   = 32;
    localparam int WORD_W   = 33;
    localparam int LAST_BIT = 32;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo_pkt_reader_if.sv
// Word input and status record output of the packet reader.
interface sync_fifo_pkt_reader_if
    import sync_fifo_pkg::*;
#(
    parameter int LEN_W = 10
) ();

    logic             in_valid;
    word_t            in_data;
    logic             in_ready;
    logic             pkt_valid;
    logic             pkt_ready;
    logic [LEN_W-1:0] pkt_len;
    logic [31:0]      pkt_sum;
    logic             pkt_ovf;
    logic [15:0]      pkt_cnt;

    // master: FIFO side and status consumer; slave: the reader itself
    modport master (
        output in_valid, in_data, pkt_ready,
        input  in_ready, pkt_valid, pkt_len, pkt_sum, pkt_ovf, pkt_cnt
    );

    modport slave (
        input  in_valid, in_data, pkt_ready,
        output in_ready, pkt_valid, pkt_len, pkt_sum, pkt_ovf, pkt_cnt
    );

endinterface

// File: rtl/sync_fifo_pkt_reader.sv
// Packet reader: counts and sums words from a registered-read FIFO port and
// reports one {len, sum, ovf} record per packet.
module sync_fifo_pkt_reader
    import sync_fifo_pkg::*;
#(
    parameter int LEN_W   = 10,
    parameter int MAX_LEN = 1023
) (
    input logic                   clk,
    input logic                   nrst,
    sync_fifo_pkt_reader_if.slave bus
);

    localparam logic [31:0] MAX_LEN_U = 32'(MAX_LEN);

    state_t            state;
    logic              pend;
    logic [LEN_W-1:0]  acc_len;
    logic [DATA_W-1:0] acc_sum;
    logic              acc_ovf;

    logic              hs;
    logic [LEN_W:0]    len_inc;
    logic [LEN_W-1:0]  len_next;
    logic [DATA_W-1:0] sum_next;
    logic              ovf_next;

    // A word is in flight while pend is set; no new handshake until it lands.
    assign bus.in_ready = ~pend & ~bus.pkt_valid;
    assign hs           = bus.in_valid & bus.in_ready;

    assign len_inc  = {1'b0, acc_len} + 1'b1;
    assign len_next = len_inc[LEN_W] ? '1 : len_inc[LEN_W-1:0];
    assign sum_next = acc_sum + bus.in_data.data;
    assign ovf_next = acc_ovf | (32'(len_inc) > MAX_LEN_U);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            pend          <= 1'b0;
            acc_len       <= '0;
            acc_sum       <= '0;
            acc_ovf       <= 1'b0;
            bus.pkt_valid <= 1'b0;
            bus.pkt_len   <= '0;
            bus.pkt_sum   <= '0;
            bus.pkt_ovf   <= 1'b0;
            bus.pkt_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        pend  <= 1'b1;
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (pend) begin
                        pend <= 1'b0;
                        if (bus.in_data.last) begin
                            bus.pkt_len   <= len_next;
                            bus.pkt_sum   <= sum_next;
                            bus.pkt_ovf   <= ovf_next;
                            bus.pkt_valid <= 1'b1;
                            acc_len       <= '0;
                            acc_sum       <= '0;
                            acc_ovf       <= 1'b0;
                            state         <= REPORT;
                        end else begin
                            acc_len <= len_next;
                            acc_sum <= sum_next;
                            acc_ovf <= ovf_next;
                        end
                    end else if (hs) begin
                        pend <= 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.pkt_ready) begin
                        bus.pkt_valid <= 1'b0;
                        bus.pkt_cnt   <= bus.pkt_cnt + 16'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_pkt_reader.sv
// Scoreboard bench: two readers (default and MAX_LEN=4/LEN_W=3) fed identically.
module tb_sync_fifo_pkt_reader;
    import sync_fifo_pkg::*;

    typedef struct {
        logic [9:0]  len;
        logic [31:0] sum;
        logic        ovf;
    } rec_t;

    logic  clk = 1'b0;
    logic  nrst = 1'b0;
    logic  in_valid;
    logic  pkt_ready;
    word_t in_data;

    always #5 clk = ~clk;

    sync_fifo_pkt_reader_if #(.LEN_W(10)) bus_a ();
    sync_fifo_pkt_reader_if #(.LEN_W(3))  bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.pkt_ready = pkt_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.pkt_ready = pkt_ready;

    sync_fifo_pkt_reader #(.LEN_W(10), .MAX_LEN(1023)) dut_a (.clk(clk), .nrst(nrst), .bus(bus_a));
    sync_fifo_pkt_reader #(.LEN_W(3),  .MAX_LEN(4))    dut_b (.clk(clk), .nrst(nrst), .bus(bus_b));

    word_t       words[$];
    rec_t        qa[$];
    rec_t        qb[$];
    logic [31:0] pk[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_hs_cyc = -100;
    int          pr_mode = 0;
    int          stall_pct = 0;
    int          exp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue the words of pk and the expected record for each reader.
    task automatic send_pkt();
        int unsigned n;
        logic [31:0] s;
        rec_t        r;
        n = pk.size();
        s = '0;
        for (int unsigned i = 0; i < n; i++) begin
            words.push_back('{last: (i == n - 1), data: pk[i]});
            s = s + pk[i];
        end
        r.sum = s;
        r.len = (n > 1023) ? 10'd1023 : 10'(n);
        r.ovf = (n > 1023);
        qa.push_back(r);
        r.len = (n > 7) ? 10'd7 : 10'(n);
        r.ovf = (n > 4);
        qb.push_back(r);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while ((words.size() != 0 || qa.size() != 0 || qb.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            tests++;
            fails++;
            $display("FAIL timeout: words=%0d qa=%0d qb=%0d left after %0d cycles",
                     words.size(), qa.size(), qb.size(), budget);
            words.delete();
            qa.delete();
            qb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // FIFO model: data is presented the cycle after the handshake, garbage otherwise.
    initial begin
        word_t cur;
        logic  hs_pend;
        hs_pend = 1'b0;
        cur     = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!nrst) begin
                in_valid = 1'b0;
                hs_pend  = 1'b0;
                in_data  = word_t'({$urandom, $urandom});
            end else begin
                in_data  = hs_pend ? cur : word_t'({$urandom, $urandom});
                hs_pend  = 1'b0;
                in_valid = (words.size() != 0) && ($urandom_range(99) >= 32'(stall_pct));
            end
            pkt_ready = (pr_mode == 0) ? 1'b1 : (pr_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
            @(negedge clk);
            if (nrst && in_valid && bus_a.in_ready) begin
                cur     = words.pop_front();
                hs_pend = 1'b1;
                if (cur.last) last_hs_cyc = cyc;
            end
        end
    end

    // Monitor: compare records at handshake and check record-port timing rules.
    initial begin
        logic        prev_valid;
        logic        acc_flag;
        logic [9:0]  h_len;
        logic [31:0] h_sum;
        logic        h_ovf;
        rec_t        r;
        prev_valid = 1'b0;
        acc_flag   = 1'b0;
        h_len = '0; h_sum = '0; h_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                prev_valid = 1'b0;
                acc_flag   = 1'b0;
                exp_cnt    = 0;
            end else begin
                if (acc_flag) check("valid_drop", 64'(bus_a.pkt_valid), 64'd0);
                acc_flag = 1'b0;
                if (bus_a.pkt_valid && !prev_valid)
                    check("latency", 64'(cyc), 64'(last_hs_cyc + 2));
                if (bus_a.pkt_valid && prev_valid) begin
                    check("hold_len", 64'(bus_a.pkt_len), 64'(h_len));
                    check("hold_sum", 64'(bus_a.pkt_sum), 64'(h_sum));
                    check("hold_ovf", 64'(bus_a.pkt_ovf), 64'(h_ovf));
                end
                if (bus_a.pkt_valid && bus_a.in_ready)
                    check("in_ready_blocked", 64'(bus_a.in_ready), 64'd0);
                if (bus_a.pkt_valid && pkt_ready) begin
                    if (qa.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_rec_a: len=%0d sum=0x%0h, none expected",
                                 bus_a.pkt_len, bus_a.pkt_sum);
                    end else begin
                        r = qa.pop_front();
                        check("a_len", 64'(bus_a.pkt_len), 64'(r.len));
                        check("a_sum", 64'(bus_a.pkt_sum), 64'(r.sum));
                        check("a_ovf", 64'(bus_a.pkt_ovf), 64'(r.ovf));
                    end
                    check("a_cnt", 64'(bus_a.pkt_cnt), 64'(16'(exp_cnt)));
                    exp_cnt++;
                    acc_flag = 1'b1;
                end
                if (bus_b.pkt_valid && pkt_ready) begin
                    if (qb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_rec_b: len=%0d sum=0x%0h, none expected",
                                 bus_b.pkt_len, bus_b.pkt_sum);
                    end else begin
                        r = qb.pop_front();
                        check("b_len", 64'(bus_b.pkt_len), 64'(r.len));
                        check("b_sum", 64'(bus_b.pkt_sum), 64'(r.sum));
                        check("b_ovf", 64'(bus_b.pkt_ovf), 64'(r.ovf));
                    end
                end
                prev_valid = bus_a.pkt_valid;
                h_len = bus_a.pkt_len;
                h_sum = bus_a.pkt_sum;
                h_ovf = bus_a.pkt_ovf;
            end
        end
    end

    initial begin
        int          sz;
        int          k;
        int unsigned n;
        in_valid = 1'b0;
        pkt_ready = 1'b1;
        in_data = '0;
        repeat (3) @(posedge clk);
        #3 nrst = 1'b1;

        // Reset mid-packet with a word in flight: partial packet must vanish.
        words.push_back('{last: 1'b0, data: 32'h10});
        words.push_back('{last: 1'b0, data: 32'h20});
        k = 0;
        while (words.size() != 0 && k < 50) begin @(negedge clk); k++; end
        check("pre_reset_drain", 64'(words.size()), 64'd0);
        @(posedge clk); #3 nrst = 1'b0;
        words.delete();
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        check("rst_pkt_valid", 64'(bus_a.pkt_valid), 64'd0);
        check("rst_pkt_len", 64'(bus_a.pkt_len), 64'd0);
        check("rst_pkt_sum", 64'(bus_a.pkt_sum), 64'd0);
        check("rst_pkt_ovf", 64'(bus_a.pkt_ovf), 64'd0);
        check("rst_pkt_cnt", 64'(bus_a.pkt_cnt), 64'd0);
        check("rst_b_valid", 64'(bus_b.pkt_valid), 64'd0);
        @(posedge clk); #3 nrst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        check("post_rst_pkt_valid", 64'(bus_a.pkt_valid), 64'd0);

        // Basic 3-word packet: len 3, sum 6.
        pk = {32'h1, 32'h2, 32'h3};
        send_pkt();
        wait_done(200);
        check("cnt_after_first", 64'(bus_a.pkt_cnt), 64'd1);

        // Single max word, then a wrapping 2-word sum.
        pk = {32'hFFFF_FFFF};
        send_pkt();
        pk = {32'hFFFF_FFFF, 32'h2};
        send_pkt();
        wait_done(200);

        // Consumer stall: record holds, input blocked, FIFO untouched.
        pr_mode = 2;
        pk = {32'd10, 32'd20};
        send_pkt();
        pk = {32'd5};
        send_pkt();
        k = 0;
        while (!bus_a.pkt_valid && k < 50) begin @(negedge clk); k++; end
        check("stall_rec_seen", 64'(bus_a.pkt_valid), 64'd1);
        sz = words.size();
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus_a.in_ready), 64'd0);
            check("stall_fill", 64'(words.size()), 64'(sz));
        end
        check("stall_cnt", 64'(bus_a.pkt_cnt), 64'd3);
        pr_mode = 0;
        wait_done(200);
        check("cnt_after_stall", 64'(bus_a.pkt_cnt), 64'd5);

        // Overflow boundary on the MAX_LEN=4 reader, plus length saturation at 7.
        pk = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        send_pkt();
        pk = {32'd7, 32'd8};
        send_pkt();
        pk = {32'd1, 32'd1, 32'd1, 32'd1};
        send_pkt();
        pk = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        send_pkt();
        wait_done(400);

        // Random stalls on both ports.
        stall_pct = 40;
        pr_mode = 1;
        for (int p = 0; p < 200; p++) begin
            n = $urandom_range(10, 1);
            pk.delete();
            for (int unsigned i = 0; i < n; i++) pk.push_back($urandom);
            send_pkt();
        end
        wait_done(30000);
        check("final_cnt", 64'(bus_a.pkt_cnt), 64'd209);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
